// File: rtl/load_mem_responder.sv
// Load-memory responder: queues load requests in an in-order FIFO and answers
// each one from a preloadable backing store after a fixed WAIT dwell.
module load_mem_responder #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned LQ_SIZE   = 8,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 4,
  localparam int unsigned TAG_W    = $clog2(LQ_SIZE),
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 req_valid_in,
  input  logic [WORD_SIZE-1:0] req_addr_in,
  input  logic [TAG_W-1:0]     req_tag_in,
  output logic                 resp_valid_out,
  output logic [WORD_SIZE-1:0] resp_data_out,
  output logic [TAG_W-1:0]     resp_tag_out,
  input  logic                 pre_wr_en_in,
  input  logic [IDX_W-1:0]     pre_wr_idx_in,
  input  logic [WORD_SIZE-1:0] pre_wr_data_in,
  output logic                 busy_out,
  output logic                 overflow_err_out
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FILL_W = TAG_W + 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]     fifo_idx_q [LQ_SIZE];
  logic [TAG_W-1:0]     fifo_tag_q [LQ_SIZE];
  logic [TAG_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]    fill_q;
  logic                 fifo_empty, fifo_full;
  logic                 push, pop, drop, fire;

  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     work_idx_q;
  logic [TAG_W-1:0]     work_tag_q;
  logic [WORD_SIZE-1:0] resp_data_q;
  logic [TAG_W-1:0]     resp_tag_q;
  logic                 ovf_q;

  logic [WORD_SIZE-1:0] mem_q [MEM_WORDS];

  // Only the word index is kept: low bits align down, high bits wrap.
  logic [IDX_W-1:0]     req_idx;
  logic                 unused_addr_bits;

  assign req_idx          = req_addr_in[IDX_W+2:3];
  assign unused_addr_bits = ^{req_addr_in[WORD_SIZE-1:IDX_W+3], req_addr_in[2:0]};

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(LQ_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO handshake: a pop in the same edge frees the slot for a push when full.
  always_comb begin
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == FILL_W'(LQ_SIZE));
    pop        = (state_q == StIdle) && !fifo_empty;
    push       = req_valid_in && (!fifo_full || pop);
    drop       = req_valid_in && fifo_full && !pop;
    fire       = (state_q == StWait) && (cnt_q == '0);
  end

  // FIFO payload storage; occupancy is tracked separately so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= req_idx;
      fifo_tag_q[wr_ptr_q] <= req_tag_in;
    end
  end

  // Backing store preload port; contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (pre_wr_en_in) begin
      mem_q[pre_wr_idx_in] <= pre_wr_data_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      fill_q <= fill_q + 1'b1;
      else if (pop && !push) fill_q <= fill_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StWait;
      StWait:  if (cnt_q == '0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    resp_valid_out = (state_q == StResp);
    busy_out       = !fifo_empty || (state_q != StIdle);
  end

  // Working registers, dwell counter and registered response payload.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      cnt_q       <= '0;
      work_idx_q  <= '0;
      work_tag_q  <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      if (pop) begin
        cnt_q      <= CNT_W'(LATENCY - 1);
        work_idx_q <= fifo_idx_q[rd_ptr_q];
        work_tag_q <= fifo_tag_q[rd_ptr_q];
      end else if ((state_q == StWait) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Read sees the pre-edge store, so a same-edge preload is not visible.
      if (fire) begin
        resp_data_q <= mem_q[work_idx_q];
        resp_tag_q  <= work_tag_q;
      end
    end
  end

  assign resp_data_out    = resp_data_q;
  assign resp_tag_out     = resp_tag_q;
  assign overflow_err_out = ovf_q;

endmodule

// File: tb/tb_load_mem_responder.sv
// Self-checking bench for load_mem_responder: directed vectors, multi-cycle
// corner sequences and random traffic against a transaction-level model.
module tb_load_mem_responder;

  localparam int unsigned WS  = 64;
  localparam int unsigned LQ  = 8;
  localparam int unsigned MW  = 256;
  localparam int unsigned LAT = 4;
  localparam int unsigned TW  = 3;
  localparam int unsigned IW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic [WS-1:0] req_addr = '0;
  logic [TW-1:0] req_tag = '0;
  logic          resp_valid;
  logic [WS-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          pre_wr_en = 1'b0;
  logic [IW-1:0] pre_wr_idx = '0;
  logic [WS-1:0] pre_wr_data = '0;
  logic          busy;
  logic          ovf;

  load_mem_responder #(
    .WORD_SIZE (WS),
    .LQ_SIZE   (LQ),
    .MEM_WORDS (MW),
    .LATENCY   (LAT)
  ) dut (
    .clk_in           (clk),
    .rst_N_in         (rst_n),
    .req_valid_in     (req_valid),
    .req_addr_in      (req_addr),
    .req_tag_in       (req_tag),
    .resp_valid_out   (resp_valid),
    .resp_data_out    (resp_data),
    .resp_tag_out     (resp_tag),
    .pre_wr_en_in     (pre_wr_en),
    .pre_wr_idx_in    (pre_wr_idx),
    .pre_wr_data_in   (pre_wr_data),
    .busy_out         (busy),
    .overflow_err_out (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: a request queue served by one server that takes
  // LAT+2 edges per request and answers LAT edges after taking it.
  typedef struct packed {
    logic [WS-1:0] addr;
    logic [TW-1:0] tag;
  } req_t;

  req_t          mq[$];
  req_t          cur;
  logic [WS-1:0] mmem [MW];
  int            edge_n = 0;
  int            next_free = 0;
  int            resp_edge = -100;
  logic [WS-1:0] m_data = '0;
  logic [TW-1:0] m_tag = '0;
  logic          m_ovf = 1'b0;

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input logic v, input logic [WS-1:0] a, input logic [TW-1:0] t,
                      input logic we, input logic [IW-1:0] wi, input logic [WS-1:0] wd);
    req_t nr;
    req_valid   = v;
    req_addr    = a;
    req_tag     = t;
    pre_wr_en   = we;
    pre_wr_idx  = wi;
    pre_wr_data = wd;
    @(posedge clk);
    edge_n++;
    if (edge_n >= next_free && mq.size() != 0) begin
      cur       = mq.pop_front();
      resp_edge = edge_n + LAT;
      next_free = edge_n + LAT + 2;
    end
    if (edge_n == resp_edge) begin
      m_data = mmem[int'((cur.addr >> 3) % MW)];
      m_tag  = cur.tag;
    end
    if (v) begin
      if (mq.size() < LQ) begin
        nr.addr = a;
        nr.tag  = t;
        mq.push_back(nr);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (we) mmem[wi] = wd;
    #1;
    chk("resp_valid", resp_valid, (edge_n == resp_edge));
    chk("resp_data", resp_data, m_data);
    chk("resp_tag", resp_tag, m_tag);
    chk("busy", busy, (mq.size() != 0) || (edge_n < next_free - 1));
    chk("overflow_err", ovf, m_ovf);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    req_valid = 1'b0;
    pre_wr_en = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete();
    next_free = 0;
    resp_edge = -100;
    m_data    = '0;
    m_tag     = '0;
    m_ovf     = 1'b0;
  endtask

  typedef struct {
    logic [IW-1:0] idx;
    logic [WS-1:0] wdata;
    logic [WS-1:0] addr;
    logic [TW-1:0] tag;
    logic [WS-1:0] exp_data;
  } vec_t;

  vec_t          vecs[4];
  int            seen, seen_k, n_resp, busy_drop, cnt;
  int            r_edge[3];
  logic [TW-1:0] r_tag[3];
  logic [WS-1:0] got_d;
  logic [TW-1:0] got_t;

  initial begin
    vecs[0] = '{8'd5,   64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0000_0028, 3'd3,
                64'h0000_0000_DEAD_BEEF};
    vecs[1] = '{8'd0,   64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0803, 3'd6,
                64'h1234_5678_9ABC_DEF0};
    vecs[2] = '{8'd255, 64'hFFFF_0000_AAAA_5555, 64'h0000_0000_0000_07FF, 3'd2,
                64'hFFFF_0000_AAAA_5555};
    vecs[3] = '{8'd1,   64'h0BAD_CAFE_0000_0001, 64'hFFFF_FFFF_FFFF_F80F, 3'd7,
                64'h0BAD_CAFE_0000_0001};
    r_edge = '{0, 0, 0};
    r_tag  = '{0, 0, 0};

    #1 do_reset();

    // Fill the whole store with distinct values.
    for (int i = 0; i < int'(MW); i++) begin
      step(1'b0, '0, '0, 1'b1, IW'(i), {$urandom, $urandom});
    end

    // Single requests: latency, single pulse, alignment and wrap.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, vecs[i].idx, vecs[i].wdata);
      step(1'b1, vecs[i].addr, vecs[i].tag, 1'b0, '0, '0);
      seen = 0;
      seen_k = 0;
      got_d = '0;
      got_t = '0;
      for (int k = 1; k <= int'(LAT) + 3; k++) begin
        idle();
        if (resp_valid) begin
          seen++;
          seen_k = k;
          got_d  = resp_data;
          got_t  = resp_tag;
        end
      end
      chk("vec_pulses", seen, 1);
      chk("vec_latency", seen_k, LAT + 1);
      chk("vec_data", got_d, vecs[i].exp_data);
      chk("vec_tag", got_t, vecs[i].tag);
    end

    // Back-to-back tags 1,2,3: in order, LAT+2 apart, busy held throughout.
    step(1'b1, 64'h10, 3'd1, 1'b0, '0, '0);
    step(1'b1, 64'h18, 3'd2, 1'b0, '0, '0);
    step(1'b1, 64'h20, 3'd3, 1'b0, '0, '0);
    n_resp = 0;
    busy_drop = 0;
    for (int k = 0; k < 40 && n_resp < 3; k++) begin
      idle();
      if (!busy) busy_drop++;
      if (resp_valid) begin
        r_tag[n_resp]  = resp_tag;
        r_edge[n_resp] = edge_n;
        n_resp++;
      end
    end
    chk("b2b_count", n_resp, 3);
    chk("b2b_tag0", r_tag[0], 1);
    chk("b2b_tag1", r_tag[1], 2);
    chk("b2b_tag2", r_tag[2], 3);
    chk("b2b_gap01", r_edge[1] - r_edge[0], LAT + 2);
    chk("b2b_gap12", r_edge[2] - r_edge[1], LAT + 2);
    chk("b2b_busy_drops", busy_drop, 0);
    repeat (4) idle();

    // Overflow: with LAT=4 the server still drains during a burst, so 11
    // consecutive requests are needed to fill all 8 slots and lose one.
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, WS'(64'h100 + i * 8), TW'(i), 1'b0, '0, '0);
      if (resp_valid) cnt++;
      if (i == 9)  chk("ovf_before_drop", ovf, 0);
      if (i == 10) chk("ovf_after_drop", ovf, 1);
    end
    for (int k = 0; k < 80; k++) begin
      idle();
      if (resp_valid) cnt++;
    end
    chk("ovf_answered", cnt, 10);
    chk("ovf_sticky", ovf, 1);

    // Preload on the WAIT->RESP edge is not seen; the next request sees it.
    step(1'b0, '0, '0, 1'b1, 8'd9, 64'h1111_1111_1111_1111);
    step(1'b1, 64'h48, 3'd4, 1'b0, '0, '0);
    got_d = '0;
    for (int k = 1; k <= int'(LAT) + 3; k++) begin
      if (k == int'(LAT) + 1) step(1'b0, '0, '0, 1'b1, 8'd9, 64'h2222_2222_2222_2222);
      else idle();
      if (resp_valid) got_d = resp_data;
    end
    chk("same_edge_old", got_d, 64'h1111_1111_1111_1111);
    step(1'b1, 64'h48, 3'd5, 1'b0, '0, '0);
    got_d = '0;
    for (int k = 1; k <= int'(LAT) + 3; k++) begin
      idle();
      if (resp_valid) got_d = resp_data;
    end
    chk("same_edge_new", got_d, 64'h2222_2222_2222_2222);

    // Reset in WAIT with two requests queued: nothing may come out later.
    step(1'b1, 64'h30, 3'd0, 1'b0, '0, '0);
    step(1'b1, 64'h38, 3'd1, 1'b0, '0, '0);
    step(1'b1, 64'h40, 3'd2, 1'b0, '0, '0);
    idle();
    idle();
    do_reset();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (resp_valid) cnt++;
    end
    chk("post_reset_no_resp", cnt, 0);
    chk("post_reset_busy", busy, 0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 2) != 0, {$urandom, $urandom}, TW'($urandom),
           $urandom_range(0, 7) == 0, IW'($urandom), {$urandom, $urandom});
    end
    for (int k = 0; k < 80; k++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
